md_ctrl: RTL and testbench
==========================

MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYC, default 5, cycles from multiply start to HI/LO update (legal range 1..15).
REQ-002 SHALL have parameter DIV_CYC, default 10, cycles from divide start to HI/LO update (legal range 1..15).
REQ-003 SHALL have port Clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port Rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Start  input  1  an MD instruction is presented this cycle.
REQ-006 SHALL have port Op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6..7 no-op.
REQ-007 SHALL have port A  input  32  rs operand (also the MTHI/MTLO data).
REQ-008 SHALL have port B  input  32  rt operand.
REQ-009 SHALL have port Flush  input  1  exception/interrupt cancel of the instruction presented this cycle.
REQ-010 SHALL have port Busy  output  1  multiply/divide in progress; upstream stalls MD instructions while it is high.
REQ-011 SHALL have port Done  output  1  one-cycle pulse; HI/LO just updated by a multiply/divide.
REQ-012 SHALL have ports HI and LO  output  32 each  architectural HI/LO registers, registered outputs.

Function
REQ-013 SHALL implement the states IDLE and RUN with a 4-bit down-counter CNT.
REQ-014 In IDLE, a rising edge with Start=1, Flush=0 and Op in 0..3 SHALL capture the result into pending registers, load CNT with MUL_CYC-1 (Op 0/1) or DIV_CYC-1 (Op 2/3), and enter RUN.
REQ-015 Busy SHALL equal (state==RUN); with a start at edge t0, Busy is high for exactly N cycles, where N is MUL_CYC or DIV_CYC.
REQ-016 In RUN, each edge with CNT!=0 SHALL decrement CNT; the edge with CNT==0 SHALL write the pending values to HI/LO, return to IDLE, and set Done=1 for the following cycle.
REQ-017 HI/LO SHALL be updated by a multiply/divide only at edge t0+N and SHALL be unchanged until then.
REQ-018 MULT/MULTU SHALL produce a 64-bit signed/unsigned product, with HI = bits[63:32] and LO = bits[31:0].
REQ-019 DIV/DIVU SHALL produce LO = quotient truncated toward zero and HI = remainder (for DIV, remainder takes the sign of the dividend); DIV 0x80000000/0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-020 MTHI/MTLO with Start=1 and Flush=0 in IDLE SHALL write A to HI/LO at that edge, leave Busy low, and leave Done low.
REQ-021 Start with Flush=1 SHALL be ignored entirely, with no state, counter, or HI/LO change.
REQ-022 Flush while in RUN SHALL NOT cancel the running operation.
REQ-023 Start while in RUN (protocol violation) SHALL be ignored, with the running operation unaffected.
REQ-024 Op 6..7 SHALL be ignored.

Reset
REQ-025 Rst low SHALL immediately force state=IDLE, CNT=0, Busy=0, Done=0, HI=0, LO=0, and pending registers=0, regardless of Clk.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no HI/LO update after release.
REQ-027 The first Start sampled after reset release SHALL be accepted normally.

Configuration
REQ-028 Macro MD_DIV0_GUARD_EN defined: DIV/DIVU with B=0 SHALL still run DIV_CYC cycles and pulse Done, but leave HI/LO unchanged.
REQ-029 Macro MD_DIV0_GUARD_EN undefined: DIV/DIVU with B=0 SHALL produce HI=A, LO=0xFFFFFFFF after DIV_CYC cycles.

Verification
REQ-030 MULT with A=0xFFFFFFFE, B=3 at t0 -> Busy high 5 cycles; at t0+5: HI=0xFFFFFFFF, LO=0xFFFFFFFA; Done pulses once.
REQ-031 DIVU with A=7, B=2 followed by DIV with A=-7, B=2 -> HI=1, LO=3, then HI=0xFFFFFFFF, LO=0xFFFFFFFD, each after 10 cycles.
REQ-032 MTHI with A=0x1234 in IDLE -> HI=0x1234 next cycle, Busy=0, Done=0; MTLO issued during RUN -> ignored.
REQ-033 Start with Flush=1 and Op=MULT -> Busy stays 0 and HI/LO unchanged; MULT started, then Flush=1 at t0+2 -> completes normally at t0+5.
REQ-034 Rst low at t0+3 of a DIV -> immediately Busy=0, HI=LO=0; after release, a MULTU 3x4 completes at its start+5 with LO=12.
REQ-035 DIV with B=0 and A=5 -> with the macro defined, HI/LO hold their old values; with it undefined, HI=5, LO=0xFFFFFFFF.

Source files
------------

// File: rtl/md_ctrl.sv
// -----------------------------------------------------------------------------
// md_ctrl -- multiply/divide controller that owns the architectural HI/LO pair.
//
// A MULT/MULTU/DIV/DIVU accepted in IDLE has its 64-bit result computed at
// once and parked in pending registers. The FSM then sits in RUN for
// MUL_CYC or DIV_CYC cycles. Parking the result keeps HI/LO unchanged until
// the modelled latency has elapsed. MTHI/MTLO write HI/LO directly at the
// accepting edge.
//
// Parameters
//   MUL_CYC : cycles from multiply start to HI/LO update (1..15)
//   DIV_CYC : cycles from divide start to HI/LO update (1..15)
//
// Ports
//   Clk    in   1   clock, rising edge
//   Rst    in   1   asynchronous reset, active low
//   Start  in   1   MD instruction presented this cycle
//   Op     in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6..7 no-op
//   A      in   32  rs operand / MTHI-MTLO data
//   B      in   32  rt operand
//   Flush  in   1   cancels the instruction presented this cycle
//   Busy   out  1   multiply/divide in progress
//   Done   out  1   one-cycle pulse after HI/LO were written by mul/div
//   HI,LO  out  32  architectural HI/LO registers
//
// Optional feature
//   MD_DIV0_GUARD_EN : when defined, a divide by zero still runs and pulses
//                      Done but leaves HI/LO untouched. When undefined, it
//                      yields HI=A and LO=0xFFFFFFFF.
// -----------------------------------------------------------------------------
module md_ctrl #(
  parameter int MUL_CYC = 5,
  parameter int DIV_CYC = 10
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Flush,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYC - 1);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYC - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        done_nxt;
  logic [31:0] pend_hi, pend_lo;
  logic        pend_wr;

  logic        accept, is_mul, is_div, div0, wr_ok;
  logic [31:0] res_hi, res_lo;
  logic signed [63:0] prod_s;
  logic [63:0] prod_u;

  // Unsigned divide returning {remainder, quotient}; divide by zero gives
  // {dividend, all-ones}.
  function automatic logic [63:0] div_u(input logic [31:0] n, input logic [31:0] d);
    logic [31:0] q, r;
    if (d == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = n;
    end else begin
      q = n / d;
      r = n % d;
    end
    return {r, q};
  endfunction

  // Signed divide built on magnitudes so that 0x80000000 / -1 is well
  // defined (quotient 0x80000000, remainder 0). The quotient truncates
  // toward zero and the remainder takes the dividend's sign.
  function automatic logic [63:0] div_s(input logic [31:0] n, input logic [31:0] d);
    logic [31:0] an, ad, q, r;
    logic [63:0] ur;
    if (d == 32'd0) begin
      return {n, 32'hFFFF_FFFF};
    end
    an = n[31] ? -n : n;
    ad = d[31] ? -d : d;
    ur = div_u(an, ad);
    q  = (n[31] ^ d[31]) ? -ur[31:0] : ur[31:0];
    r  = n[31] ? -ur[63:32] : ur[63:32];
    return {r, q};
  endfunction

  assign accept = (state == IDLE) && Start && !Flush;
  assign is_mul = (Op == 3'd0) || (Op == 3'd1);
  assign is_div = (Op == 3'd2) || (Op == 3'd3);
  assign div0   = is_div && (B == 32'd0);

`ifdef MD_DIV0_GUARD_EN
  assign wr_ok = !div0;
`else
  assign wr_ok = 1'b1;
`endif

  assign prod_s = $signed(A) * $signed(B);
  assign prod_u = {32'd0, A} * {32'd0, B};

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (Op)
      3'd0:    {res_hi, res_lo} = prod_s;
      3'd1:    {res_hi, res_lo} = prod_u;
      3'd2:    {res_hi, res_lo} = div_s(A, B);
      3'd3:    {res_hi, res_lo} = div_u(A, B);
      default: ;
    endcase
  end

  // Next-state / counter / Done
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (accept && (is_mul || is_div)) begin
          state_nxt = RUN;
          cnt_nxt   = is_mul ? MUL_LOAD : DIV_LOAD;
        end
      end
      RUN: begin
        if (cnt == 4'd0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      Done    <= 1'b0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
      HI      <= 32'd0;
      LO      <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      Done  <= done_nxt;
      if (accept && (is_mul || is_div)) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        pend_wr <= wr_ok;
      end
      if ((state == RUN) && (cnt == 4'd0)) begin
        if (pend_wr) begin
          HI <= pend_hi;
          LO <= pend_lo;
        end
      end else if (accept && (Op == 3'd4)) begin
        HI <= A;
      end else if (accept && (Op == 3'd5)) begin
        LO <= A;
      end
    end
  end

  assign Busy = (state == RUN);

endmodule

// File: tb/tb_md_ctrl.sv
module tb_md_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic        Flush;
  logic        Busy, Done;
  logic [31:0] HI, LO;

  int passed = 0;
  int total  = 0;

  md_ctrl #(.MUL_CYC(5), .DIV_CYC(10)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .Flush(Flush), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue one mul/div at the next edge (t0), then follow it to t0+n+1.
  task automatic run_md(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input int n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] hi0, lo0;
    hi0 = HI;
    lo0 = LO;
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clk); #1;
    Start = 1'b0;
    chk({tag, " busy@t0"}, {31'd0, Busy}, 32'd1);
    for (int k = 1; k < n; k++) begin
      @(posedge Clk); #1;
      chk({tag, " busy"}, {31'd0, Busy}, 32'd1);
    end
    chk({tag, " hi held"}, HI, hi0);
    chk({tag, " lo held"}, LO, lo0);
    @(posedge Clk); #1;
    chk({tag, " busy end"}, {31'd0, Busy}, 32'd0);
    chk({tag, " done"}, {31'd0, Done}, 32'd1);
    chk({tag, " hi"}, HI, exp_hi);
    chk({tag, " lo"}, LO, exp_lo);
    @(posedge Clk); #1;
    chk({tag, " done off"}, {31'd0, Done}, 32'd0);
  endtask

  initial begin
    Rst = 1'b0; Start = 1'b0; Op = 3'd0; A = 32'd0; B = 32'd0; Flush = 1'b0;
    #3;
    chk("reset busy", {31'd0, Busy}, 32'd0);
    chk("reset done", {31'd0, Done}, 32'd0);
    chk("reset hi", HI, 32'd0);
    chk("reset lo", LO, 32'd0);
    #9 Rst = 1'b1;
    @(posedge Clk); #1;

    // -2 * 3 = -6
    run_md("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    // 0xFFFFFFFE * 3 unsigned = 0x2_FFFFFFFA
    run_md("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
    run_md("divu", 3'd3, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    run_md("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // MTHI in IDLE
    Start = 1'b1; Op = 3'd4; A = 32'h1234;
    @(posedge Clk); #1;
    Start = 1'b0;
    chk("mthi hi", HI, 32'h1234);
    chk("mthi lo", LO, 32'hFFFF_FFFD);
    chk("mthi busy", {31'd0, Busy}, 32'd0);
    chk("mthi done", {31'd0, Done}, 32'd0);

    // Start with Flush is ignored
    Start = 1'b1; Flush = 1'b1; Op = 3'd0; A = 32'd2; B = 32'd3;
    @(posedge Clk); #1;
    Start = 1'b0; Flush = 1'b0;
    chk("flush busy", {31'd0, Busy}, 32'd0);
    @(posedge Clk); #1;
    chk("flush busy2", {31'd0, Busy}, 32'd0);
    chk("flush hi", HI, 32'h1234);
    chk("flush lo", LO, 32'hFFFF_FFFD);

    // Op 6 is a no-op
    Start = 1'b1; Op = 3'd6; A = 32'hAAAA_5555;
    @(posedge Clk); #1;
    Start = 1'b0;
    chk("op6 busy", {31'd0, Busy}, 32'd0);
    chk("op6 hi", HI, 32'h1234);
    chk("op6 lo", LO, 32'hFFFF_FFFD);

    // MULT 2*3 with Flush at t0+2 and MTLO at t0+3 during RUN
    Start = 1'b1; Op = 3'd0; A = 32'd2; B = 32'd3;
    @(posedge Clk); #1;             // after t0
    Start = 1'b0;
    @(posedge Clk); #1;             // after t0+1
    Flush = 1'b1;
    @(posedge Clk); #1;             // after t0+2
    Flush = 1'b0;
    chk("runflush busy", {31'd0, Busy}, 32'd1);
    Start = 1'b1; Op = 3'd5; A = 32'hDEAD;
    @(posedge Clk); #1;             // after t0+3
    Start = 1'b0;
    chk("mtlo in run lo", LO, 32'hFFFF_FFFD);
    chk("mtlo in run busy", {31'd0, Busy}, 32'd1);
    @(posedge Clk); #1;             // after t0+4
    chk("runflush busy4", {31'd0, Busy}, 32'd1);
    @(posedge Clk); #1;             // after t0+5
    chk("runflush done", {31'd0, Done}, 32'd1);
    chk("runflush hi", HI, 32'd0);
    chk("runflush lo", LO, 32'd6);
    @(posedge Clk); #1;

    // Reset at t0+3 of a DIV
    Start = 1'b1; Op = 3'd2; A = 32'd100; B = 32'd7;
    @(posedge Clk); #1;
    Start = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    #1;
    chk("rst mid busy", {31'd0, Busy}, 32'd0);
    chk("rst mid lo", LO, 32'd0);
    chk("rst mid hi", HI, 32'd0);
    @(posedge Clk); #1;
    Rst = 1'b1;
    repeat (12) @(posedge Clk);
    #1;
    chk("rst after hi", HI, 32'd0);
    chk("rst after lo", LO, 32'd0);
    chk("rst after busy", {31'd0, Busy}, 32'd0);
    run_md("multu after rst", 3'd1, 32'd3, 32'd4, 5, 32'd0, 32'd12);

    // Divide by zero
`ifdef MD_DIV0_GUARD_EN
    run_md("div0", 3'd2, 32'd5, 32'd0, 10, 32'd0, 32'd12);
`else
    run_md("div0", 3'd2, 32'd5, 32'd0, 10, 32'd5, 32'hFFFF_FFFF);
`endif

    // Signed overflow case
    run_md("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
